fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 2, the number of prefetch buffer entries; legal values are 2 or 4.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 imem_req  out  1  instruction memory request valid.
REQ-006 imem_addr  out  32  word-aligned request address.
REQ-007 imem_gnt  in  1  memory accepts the request this cycle.
REQ-008 imem_rvalid  in  1  read data valid; one per granted request, in order, at least 1 cycle after grant.
REQ-009 imem_rdata  in  32  instruction word.
REQ-010 redirect_valid  in  1  branch/jump taken; flush and refetch.
REQ-011 redirect_pc  in  32  new fetch address.
REQ-012 stall_f  in  1  downstream decode register is holding; do not pop.
REQ-013 valid_f  out  1  instruction_f/pc_f/pc_p_four_f carry a real instruction.
REQ-014 instruction_f  out  32  head-of-buffer instruction.
REQ-015 pc_f  out  32  address of instruction_f.
REQ-016 pc_p_four_f  out  32  pc_f + 4, modulo 2^32.

Function
REQ-017 The block SHALL hold a fetch PC, a FIFO_DEPTH-entry {pc, instr} FIFO, and a 3-state FSM: ISSUE, WAIT, DROP.
REQ-018 ISSUE: imem_req SHALL be 1 iff FIFO occupancy < FIFO_DEPTH and redirect_valid=0; imem_addr = fetch PC.
REQ-019 ISSUE and imem_req && imem_gnt SHALL latch the request PC, advance the fetch PC by 4 and go to WAIT.
REQ-020 imem_req and imem_addr SHALL stay stable until granted unless a redirect occurs.
REQ-021 WAIT: imem_req=0; imem_rvalid SHALL push {latched PC, imem_rdata} into the FIFO and return to ISSUE.
REQ-022 At most one granted request SHALL be outstanding at any time.
REQ-023 Pop SHALL occur when valid_f=1 and stall_f=0; outputs update the next cycle.
REQ-024 A simultaneous push and pop on a full FIFO SHALL NOT occur, because issue is gated by occupancy; a push and pop in the same cycle on a non-full FIFO SHALL keep the occupancy unchanged.
REQ-025 valid_f SHALL equal FIFO non-empty; the outputs are driven combinationally from the FIFO head.
REQ-026 On redirect_valid=1, the block SHALL flush the FIFO, set fetch PC = {redirect_pc[31:2], 2'b00}, and suppress pop.
REQ-027 A redirect in WAIT, or in ISSUE coincident with imem_gnt, SHALL go to DROP; otherwise the FSM SHALL go to ISSUE.
REQ-028 DROP: imem_req=0; imem_rvalid SHALL discard the data without pushing and go to ISSUE.
REQ-029 A redirect in DROP SHALL update the fetch PC and remain in DROP.
REQ-030 An imem_rvalid coinciding with a redirect in WAIT SHALL be discarded, and the FSM SHALL go to ISSUE, not DROP.
REQ-031 Redirect SHALL have priority over stall_f, push and pop.
REQ-032 Fetch PC increment SHALL wrap 32'hFFFF_FFFC to 32'h0000_0000.

Reset
REQ-033 reset=1 SHALL set: fetch PC=RESET_PC, FSM=ISSUE, FIFO empty, valid_f=0, imem_req=0 in the reset cycle.
REQ-034 reset SHALL override redirect and any outstanding request; a late imem_rvalid after reset is a memory-side error and is not required to be handled.
REQ-035 The first imem_req=1 SHALL be asserted in the cycle after reset deasserts, with imem_addr=RESET_PC.

Configuration
REQ-036 With FETCH_BUBBLE_NOP_EN defined, instruction_f, pc_f and pc_p_four_f SHALL be 32'h0000_0013, 0 and 0 whenever valid_f=0.
REQ-037 Without FETCH_BUBBLE_NOP_EN, instruction_f, pc_f and pc_p_four_f SHALL be 0 whenever valid_f=0.

Verification
REQ-038 Reset, then zero-wait memory (grant immediately, rvalid next cycle), stall_f=0 -> pc_f sequence 0,4,8,C; instruction_f matches memory; pc_p_four_f=pc_f+4.
REQ-039 stall_f=1 for 5 cycles with a full 2-entry FIFO -> imem_req=0; outputs hold pc_f=8; after release, 8 then C follow with no loss or duplication.
REQ-040 Redirect to 32'h100 while in WAIT for the address-0x10 request -> 0x10 data dropped; next valid pc_f=0x100.
REQ-041 Redirect to 32'h203 coincident with imem_gnt -> DROP state; the granted response is not pushed; next imem_addr=0x200.
REQ-042 RESET_PC=32'hFFFF_FFFC -> fetch sequence FFFF_FFFC then 0000_0000; pc_p_four_f=0 for the first instruction.
REQ-043 Empty FIFO with memory stalled -> valid_f=0; instruction_f=0x13 with FETCH_BUBBLE_NOP_EN, 0 without it.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch feeding a small {pc, instr} prefetch FIFO.
// Optional FETCH_BUBBLE_NOP_EN: present a NOP (32'h13, pc 0) instead of all-zero outputs when empty.
//
// state | meaning
// ISSUE | no request outstanding; request fetch PC while the FIFO has room
// WAIT  | one granted request outstanding; its response is pushed
// DROP  | one granted request outstanding after a redirect; its response is discarded

`timescale 1ns/1ps

module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall_f,
  output logic        valid_f,
  output logic [31:0] instruction_f,
  output logic [31:0] pc_f,
  output logic [31:0] pc_p_four_f
);

  localparam int PTR_W = (FIFO_DEPTH > 2) ? 2 : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

`ifdef FETCH_BUBBLE_NOP_EN
  localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0013;
`else
  localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;
`endif

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      req_pc_q;
  logic [31:0]      pc_mem    [FIFO_DEPTH];
  logic [31:0]      instr_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             fifo_full;
  logic             latch_req;
  logic             push;
  logic             pop;

  assign fifo_full = (count_q == FULL_CNT);
  assign imem_addr = fetch_pc_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    imem_req   = 1'b0;
    latch_req  = 1'b0;
    push       = 1'b0;
    case (state_q)
      ISSUE: begin
        imem_req = !fifo_full && !redirect_valid && !reset;
        if (redirect_valid) begin
          // memory may still have taken the address this cycle; its data must be dropped
          state_d = imem_gnt ? DROP : ISSUE;
        end else if (imem_req && imem_gnt) begin
          latch_req  = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          state_d = imem_rvalid ? ISSUE : DROP;
        end else if (imem_rvalid) begin
          push    = 1'b1;
          state_d = ISSUE;
        end
      end
      DROP: begin
        if (imem_rvalid) begin
          state_d = ISSUE;
        end
      end
      default: state_d = ISSUE;
    endcase
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
    end
  end

  assign valid_f = (count_q != '0) && !reset;
  assign pop     = valid_f && !stall_f && !redirect_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ISSUE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= 32'h0000_0000;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      if (latch_req) begin
        req_pc_q <= fetch_pc_q;
      end
      if (redirect_valid) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) begin
          wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
          count_q <= count_q + CNT_W'(1);
        end else if (!push && pop) begin
          count_q <= count_q - CNT_W'(1);
        end
      end
    end
  end

  // storage needs no reset; occupancy decides what is visible
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= req_pc_q;
      instr_mem[wr_ptr_q] <= imem_rdata;
    end
  end

  assign instruction_f = valid_f ? instr_mem[rd_ptr_q] : BUBBLE_INSTR;
  assign pc_f          = valid_f ? pc_mem[rd_ptr_q] : 32'h0000_0000;
  assign pc_p_four_f   = valid_f ? (pc_mem[rd_ptr_q] + 32'd4) : 32'h0000_0000;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit; a queue-level model predicts requests and FIFO contents.
// A second instance checks RESET_PC wrap and a 4-entry FIFO.

`timescale 1ns/1ps

module tb_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] K2    = 32'hA5A5_0000;
`ifdef FETCH_BUBBLE_NOP_EN
  localparam logic [31:0] BUB = 32'h0000_0013;
`else
  localparam logic [31:0] BUB = 32'h0000_0000;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall_f = 1'b0;
  logic        valid_f;
  logic [31:0] instruction_f, pc_f, pc_p_four_f;

  fetch_unit dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall_f(stall_f),
    .valid_f(valid_f), .instruction_f(instruction_f), .pc_f(pc_f), .pc_p_four_f(pc_p_four_f)
  );

  logic        reset2 = 1'b1;
  logic        req2;
  logic [31:0] addr2;
  logic        gnt2 = 1'b0;
  logic        rv2 = 1'b0;
  logic [31:0] rdata2 = '0;
  logic        stall2 = 1'b1;
  logic        valid2;
  logic [31:0] instr2, pc2, p4_2;

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .reset(reset2),
    .imem_req(req2), .imem_addr(addr2), .imem_gnt(gnt2),
    .imem_rvalid(rv2), .imem_rdata(rdata2),
    .redirect_valid(1'b0), .redirect_pc(32'h0000_0000), .stall_f(stall2),
    .valid_f(valid2), .instruction_f(instr2), .pc_f(pc2), .pc_p_four_f(p4_2)
  );

  int checks = 0;
  int failures = 0;

  // reference model: fetch PC, outstanding request, expected FIFO contents
  logic [31:0] m_pc = RPC;
  bit          pending = 0;
  bit          pend_drop = 0;
  logic [31:0] pend_pc = '0;
  logic [31:0] sb_pc[$];
  logic [31:0] sb_in[$];
  logic [31:0] popped[$];
  int          occ_at_edge = 0;
  logic        exp_req;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // monitor: compares outputs each cycle and retires popped entries
  always @(negedge clk) begin
    #1;
    if (reset) begin
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      chk("rst_valid", {31'b0, valid_f}, 32'd0);
    end else begin
      exp_req = !redirect_valid && !pending && (sb_pc.size() < DEPTH);
      chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
      if (exp_req) chk("imem_addr", imem_addr, m_pc);
      chk("valid_f", {31'b0, valid_f}, {31'b0, sb_pc.size() != 0});
      if (sb_pc.size() != 0) begin
        chk("pc_f", pc_f, sb_pc[0]);
        chk("instruction_f", instruction_f, sb_in[0]);
        chk("pc_p_four_f", pc_p_four_f, sb_pc[0] + 32'd4);
        if (!stall_f && !redirect_valid) begin
          popped.push_back(sb_pc[0]);
          void'(sb_pc.pop_front());
          void'(sb_in.pop_front());
        end
      end else begin
        chk("bubble_instr", instruction_f, BUB);
        chk("bubble_pc", pc_f, 32'd0);
        chk("bubble_p4", pc_p_four_f, 32'd0);
      end
    end
  end

  task automatic step(input bit rst, input bit redir, input logic [31:0] rpc,
                      input bit stl, input bit gnt, input bit rv);
    bit do_rv, acc;
    int occ;
    @(negedge clk);
    do_rv = rv && pending && !rst;
    occ = sb_pc.size();
    reset = rst;
    redirect_valid = redir;
    redirect_pc = rpc;
    stall_f = stl;
    imem_gnt = gnt;
    imem_rvalid = do_rv;
    imem_rdata = $urandom;
    #2;
    if (rst) begin
      m_pc = RPC;
      sb_pc.delete();
      sb_in.delete();
      pending = 0;
      pend_drop = 0;
    end else begin
      acc = gnt && !pending && (redir || occ < DEPTH);
      if (do_rv) begin
        if (!redir && !pend_drop) begin
          sb_pc.push_back(pend_pc);
          sb_in.push_back(imem_rdata);
        end
        pending = 0;
      end
      if (redir) begin
        sb_pc.delete();
        sb_in.delete();
        if (pending) pend_drop = 1;
      end
      if (acc) begin
        pending = 1;
        pend_drop = redir;
        pend_pc = m_pc;
      end
      if (redir) m_pc = rpc & 32'hFFFF_FFFC;
      else if (acc) m_pc = m_pc + 32'd4;
    end
    occ_at_edge = occ;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 32'd0, 0, 1, 1);
  endtask

  task automatic do_reset();
    step(1, 0, 32'd0, 0, 0, 0);
    step(1, 0, 32'd0, 0, 0, 0);
    popped.delete();
  endtask

  initial begin
    logic [31:0] rpc;
    bit g;
    int grants;
    logic [31:0] gaddr;
    logic [31:0] q2[$];
    logic [31:0] qi2[$];

    // zero-wait stream
    do_reset();
    run(12);
    chk("seq_len", {31'b0, popped.size() >= 4}, 32'd1);
    if (popped.size() >= 4)
      for (int i = 0; i < 4; i++) chk("seq_pc", popped[i], 32'(i * 4));

    // full FIFO held by stall
    do_reset();
    run(6);
    repeat (7) step(0, 0, 32'd0, 1, 1, 1);
    chk("stall_req", {31'b0, imem_req}, 32'd0);
    chk("stall_valid", {31'b0, valid_f}, 32'd1);
    chk("stall_pc", pc_f, 32'h8);
    run(6);
    chk("stall_len", {31'b0, popped.size() >= 5}, 32'd1);
    if (popped.size() >= 5) begin
      chk("stall_seq2", popped[2], 32'h8);
      chk("stall_seq3", popped[3], 32'hC);
      chk("stall_seq4", popped[4], 32'h10);
    end

    // redirect while waiting on 0x10
    do_reset();
    run(9);
    step(0, 1, 32'h100, 0, 0, 0);
    popped.delete();
    step(0, 0, 32'd0, 0, 0, 1);
    run(4);
    chk("wait_redir_len", {31'b0, popped.size() >= 1}, 32'd1);
    if (popped.size() >= 1) chk("wait_redir_pc", popped[0], 32'h100);

    // redirect coincident with grant
    do_reset();
    run(2);
    step(0, 1, 32'h203, 0, 1, 0);
    step(0, 0, 32'd0, 0, 0, 1);
    chk("drop_novalid", {31'b0, valid_f}, 32'd0);
    step(0, 0, 32'd0, 0, 0, 0);
    chk("drop_nopush", {31'b0, valid_f}, 32'd0);
    chk("drop_req", {31'b0, imem_req}, 32'd1);
    chk("drop_addr", imem_addr, 32'h200);

    // redirect coincident with rvalid in WAIT goes straight back to issuing
    do_reset();
    run(1);
    step(0, 1, 32'h40, 0, 0, 1);
    step(0, 0, 32'd0, 0, 0, 0);
    chk("wait_rv_req", {31'b0, imem_req}, 32'd1);
    chk("wait_rv_addr", imem_addr, 32'h40);
    chk("wait_rv_valid", {31'b0, valid_f}, 32'd0);

    // memory stalled, empty FIFO
    do_reset();
    step(0, 0, 32'd0, 0, 0, 0);
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, RPC);
    repeat (4) step(0, 0, 32'd0, 0, 0, 0);
    chk("empty_valid", {31'b0, valid_f}, 32'd0);
    chk("empty_instr", instruction_f, BUB);

    // PC wrap through a redirect
    do_reset();
    step(0, 1, 32'hFFFF_FFFE, 0, 0, 0);
    popped.delete();
    run(6);
    chk("wrap_len", {31'b0, popped.size() >= 2}, 32'd1);
    if (popped.size() >= 2) begin
      chk("wrap_pc0", popped[0], 32'hFFFF_FFFC);
      chk("wrap_pc1", popped[1], 32'h0);
    end

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step($urandom_range(0, 999) < 3, $urandom_range(0, 99) < 5, rpc,
           $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50);
    end
    step(0, 0, 32'd0, 1, 0, 0);

    // second instance: RESET_PC wrap and 4-deep FIFO
    gnt2 = 1'b1;
    stall2 = 1'b1;
    repeat (2) @(negedge clk);
    reset2 = 1'b0;
    g = 0;
    grants = 0;
    gaddr = '0;
    for (int c = 0; c < 20; c++) begin
      rv2 = g;
      rdata2 = gaddr ^ K2;
      #1;
      g = req2 && gnt2;
      if (g) begin
        gaddr = addr2;
        grants++;
      end
      @(negedge clk);
    end
    chk("d4_grants", 32'(grants), 32'd4);
    chk("d4_valid", {31'b0, valid2}, 32'd1);
    chk("d4_req", {31'b0, req2}, 32'd0);
    chk("d4_pc", pc2, 32'hFFFF_FFFC);
    chk("d4_p4", p4_2, 32'h0);
    chk("d4_instr", instr2, 32'hFFFF_FFFC ^ K2);
    stall2 = 1'b0;
    for (int c = 0; c < 16; c++) begin
      rv2 = g;
      rdata2 = gaddr ^ K2;
      #1;
      if (valid2) begin
        q2.push_back(pc2);
        qi2.push_back(instr2);
      end
      g = req2 && gnt2;
      if (g) gaddr = addr2;
      @(negedge clk);
    end
    chk("d4_len", {31'b0, q2.size() >= 4}, 32'd1);
    if (q2.size() >= 4)
      for (int i = 0; i < 4; i++) begin
        chk("d4_seq_pc", q2[i], 32'hFFFF_FFFC + 32'(i * 4));
        chk("d4_seq_instr", qi2[i], (32'hFFFF_FFFC + 32'(i * 4)) ^ K2);
      end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
